// File: rtl/audio_nios_sd_cmd_engine_pkg.sv
// Shared definitions for the SD command-line engine: register map, status
// bit positions, frame geometry and the sequencer state type.
package audio_nios_sd_cmd_engine_pkg;

  // Avalon register addresses
  localparam logic [2:0] ADDR_ARG      = 3'd0;
  localparam logic [2:0] ADDR_CMD      = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_RESP_ARG = 3'd3;
  localparam logic [2:0] ADDR_RESP_HDR = 3'd4;
  localparam logic [2:0] ADDR_CLKDIV   = 3'd5;

  // STATUS register bit positions
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_TIMEOUT = 2;
  localparam int unsigned ST_CRC_ERR = 3;
  localparam int unsigned ST_IRQ_EN  = 4;

  // Frame geometry
  localparam int unsigned FRAME_LEN = 48;
  localparam int unsigned CRC_SPAN  = 40;
  localparam int unsigned NCC       = 8;

  // x^7 + x^3 + 1 with the x^7 term implied by the shift
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

  // Transmit shifter image: start, direction, index, argument; the CRC
  // field is spliced in while sending and the tail fills with ones.
  function automatic logic [47:0] frame_load(input logic [5:0] idx,
                                             input logic [31:0] arg);
    return {2'b01, idx, arg, 8'hFF};
  endfunction

endpackage

// File: rtl/audio_nios_sd_cmd_engine_crc7.sv
// Serial CRC7 (x^7+x^3+1, zero init), one bit per enable, MSB first.
module audio_nios_sd_crc7
  import audio_nios_sd_cmd_engine_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // Clear has priority over a data bit in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ((din ^ crc[6]) ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/audio_nios_sd_cmd_engine.sv
// SD CMD-line engine: Avalon-MM register block, free-running SD clock
// divider, 48-bit command serializer with CRC7 and response deserializer.
module audio_nios_sd_cmd_engine
  import audio_nios_sd_cmd_engine_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = 124,
  parameter int unsigned NCR_MAX   = 64
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in,
  output logic        irq
);

  localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);
  localparam logic [DIV_W-1:0]  DIV_INIT  = DIV_W'(DIV_RESET);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(NCR_MAX - 1);

  // Divider
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_cnt;
  logic             wrap;
  logic             rise_tick;
  logic             fall_tick;

  // Registers and sequencer
  state_t           state;
  logic [31:0]      arg;
  logic             resp_en;
  logic             crc_chk_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             crc_err;
  logic             irq_en;
  logic [31:0]      resp_arg;
  logic [5:0]       resp_idx;
  logic [6:0]       resp_crc;
  logic [47:0]      tx_sh;
  logic [5:0]       tx_cnt;
  logic [44:0]      rx_sh;
  logic [5:0]       rx_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]       gap_cnt;

  logic             wr;
  logic             cmd_start;
  logic             tx_en;
  logic             rx_en;
  logic [6:0]       tx_crc;
  logic [6:0]       rx_crc;
  logic [31:0]      rd_next;

  assign wr        = chipselect & ~write_n;
  assign cmd_start = wr && (address == ADDR_CMD) && !busy;

  assign wrap      = (div_cnt == div_act);
  assign rise_tick = wrap & ~sd_clk;
  assign fall_tick = wrap &  sd_clk;

  assign irq = done & irq_en;

  // SD clock divider; a new CLKDIV value is adopted only at a wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      div_act <= DIV_INIT;
      sd_clk  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      div_act <= div_reg;
      sd_clk  <= ~sd_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // CRC feed: first 40 frame bits on fall ticks (tx) and rise ticks (rx)
  always_comb begin
    tx_en = 1'b0;
    rx_en = 1'b0;
    if (fall_tick) begin
      tx_en = ((state == S_IDLE) && busy) ||
              ((state == S_SEND) && (tx_cnt < 6'(CRC_SPAN)));
    end
    if (rise_tick) begin
      rx_en = ((state == S_WAIT) && !cmd_in) ||
              ((state == S_RECV) && (rx_cnt < 6'(CRC_SPAN)));
    end
  end

  audio_nios_sd_crc7 u_tx_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_start),
    .en      (tx_en),
    .din     (tx_sh[47]),
    .crc     (tx_crc)
  );

  audio_nios_sd_crc7 u_rx_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_start),
    .en      (rx_en),
    .din     (cmd_in),
    .crc     (rx_crc)
  );

  // Register writes and command sequencer; later assignments win, so a
  // done/timeout/crc_err set beats a status clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      arg        <= '0;
      resp_en    <= 1'b0;
      crc_chk_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      crc_err    <= 1'b0;
      irq_en     <= 1'b0;
      div_reg    <= DIV_INIT;
      resp_arg   <= '0;
      resp_idx   <= '0;
      resp_crc   <= '0;
      tx_sh      <= '1;
      tx_cnt     <= '0;
      rx_sh      <= '0;
      rx_cnt     <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      cmd_out    <= 1'b1;
      cmd_oe     <= 1'b0;
    end else begin
      if (wr) begin
        case (address)
          ADDR_ARG:    arg <= writedata;
          ADDR_CLKDIV: div_reg <= writedata[DIV_W-1:0];
          ADDR_STATUS: begin
            irq_en <= writedata[ST_IRQ_EN];
            if (writedata[ST_DONE]) begin
              done    <= 1'b0;
              timeout <= 1'b0;
              crc_err <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (cmd_start) begin
        resp_en    <= writedata[8];
        crc_chk_en <= writedata[9];
        busy       <= 1'b1;
        done       <= 1'b0;
        timeout    <= 1'b0;
        crc_err    <= 1'b0;
        tx_sh      <= frame_load(writedata[5:0], arg);
      end

      case (state)
        S_IDLE: begin
          if (busy && fall_tick) begin
            state   <= S_SEND;
            cmd_oe  <= 1'b1;
            cmd_out <= tx_sh[47];
            tx_sh   <= {tx_sh[46:0], 1'b1};
            tx_cnt  <= 6'd1;
          end
        end

        // The release step has no state of its own: the fall tick after
        // bit 0 drops cmd_oe and goes straight on, so the very next rise
        // tick already counts towards the response timeout.
        S_SEND: begin
          if (fall_tick) begin
            if (tx_cnt == 6'(FRAME_LEN)) begin
              cmd_oe   <= 1'b0;
              cmd_out  <= 1'b1;
              wait_cnt <= '0;
              gap_cnt  <= '0;
              state    <= resp_en ? S_WAIT : S_GAP;
            end else begin
              if (tx_cnt == 6'(CRC_SPAN)) begin
                cmd_out <= tx_crc[6];
                tx_sh   <= {tx_crc[5:0], {42{1'b1}}};
              end else begin
                cmd_out <= tx_sh[47];
                tx_sh   <= {tx_sh[46:0], 1'b1};
              end
              tx_cnt <= tx_cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (rise_tick) begin
            if (!cmd_in) begin
              state  <= S_RECV;
              rx_sh  <= '0;
              rx_cnt <= 6'd1;
            end else if (wait_cnt == WAIT_LAST) begin
              timeout <= 1'b1;
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        // rx_sh holds response bits 45..1 when the end bit arrives
        S_RECV: begin
          if (rise_tick) begin
            if (rx_cnt == 6'(FRAME_LEN - 1)) begin
              resp_arg <= rx_sh[38:7];
              resp_idx <= rx_sh[44:39];
              resp_crc <= rx_sh[6:0];
              if (crc_chk_en && (rx_crc != rx_sh[6:0])) begin
                crc_err <= 1'b1;
              end
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              rx_sh  <= {rx_sh[43:0], cmd_in};
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end

        S_GAP: begin
          if (fall_tick) begin
            if (gap_cnt == 3'(NCC - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Read mux
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_ARG:      rd_next = arg;
      ADDR_STATUS: begin
        rd_next[ST_BUSY]    = busy;
        rd_next[ST_DONE]    = done;
        rd_next[ST_TIMEOUT] = timeout;
        rd_next[ST_CRC_ERR] = crc_err;
        rd_next[ST_IRQ_EN]  = irq_en;
      end
      ADDR_RESP_ARG: rd_next = resp_arg;
      ADDR_RESP_HDR: rd_next[12:0] = {resp_crc, resp_idx};
      ADDR_CLKDIV:   rd_next[DIV_W-1:0] = div_reg;
      default: ;
    endcase
  end

  // Registered read data, updated every cycle from the current address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_audio_nios_sd_cmd_engine.sv
// Self-checking bench for audio_nios_sd_cmd_engine: table of command
// vectors (fixed and random) against a polynomial-division reference.
`timescale 1ns/1ps
module tb_audio_nios_sd_cmd_engine;

  localparam int NCR = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sd_clk;
  logic        cmd_out;
  logic        cmd_oe;
  logic        cmd_in;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] cur_div;

  always #5 clk = ~clk;

  audio_nios_sd_cmd_engine #(.DIV_W(8), .DIV_RESET(124), .NCR_MAX(NCR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .cmd_out    (cmd_out),
    .cmd_oe     (cmd_oe),
    .cmd_in     (cmd_in),
    .irq        (irq)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          resp_en;
    bit          crc_chk;
    int          rmode;      // 0 no response, 1 card answers, 2 card silent
    logic [47:0] resp;
    logic [7:0]  div;
    bit          inject;
    bit          irq_en;
    logic [47:0] exp_frame;
    bit          exp_to;
    bit          exp_ce;
    logic [31:0] exp_rarg;
    logic [12:0] exp_hdr;
  } vec_t;

  vec_t vt[12];

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic vec_t mkv(input logic [5:0] idx, input logic [31:0] arg,
                               input bit resp_en, input bit crc_chk, input int rmode,
                               input logic [47:0] resp, input logic [7:0] div,
                               input bit inject, input bit irq_en);
    vec_t v;
    v.idx = idx; v.arg = arg; v.resp_en = resp_en; v.crc_chk = crc_chk;
    v.rmode = rmode; v.resp = resp; v.div = div; v.inject = inject; v.irq_en = irq_en;
    v.exp_frame = frame_ref(idx, arg);
    v.exp_to    = (rmode == 2);
    v.exp_ce    = (rmode == 1) && crc_chk && (resp[7:1] != crc_ref(resp[47:8]));
    v.exp_rarg  = resp[39:8];
    v.exp_hdr   = {resp[7:1], resp[45:40]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sd_edge(input logic want);
    logic prev;
    prev = sd_clk;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (sd_clk !== prev && sd_clk === want) return;
      prev = sd_clk;
    end
    total++; bad++;
    $display("FAIL sd_edge: no sd_clk edge within 2000 clk, level %0b", want);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] d;
    logic [47:0] fr;
    bit oe_ok, seen;
    if (v.div != cur_div) begin
      bus_write(3'd5, {24'b0, v.div});
      cur_div = v.div;
      repeat (3) sd_edge(1'b1);
    end
    bus_write(3'd2, {27'b0, v.irq_en, 4'b0010});
    bus_write(3'd0, v.arg);
    bus_read(3'd0, d);
    chk("arg_readback", d, v.arg);
    cmd_in = 1'b1;
    bus_write(3'd1, {22'b0, v.crc_chk, v.resp_en, 2'b0, v.idx});
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk); #1;
      seen = cmd_oe;
    end
    chk("oe_start", seen, 1);
    if (!seen) return;
    fr = '0; oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      sd_edge(1'b1);
      fr = {fr[46:0], cmd_out};
      oe_ok = oe_ok & cmd_oe;
      if (v.inject && i == 10)
        bus_write(3'd1, {22'b0, ~v.crc_chk, ~v.resp_en, 2'b0, ~v.idx});
    end
    chk("frame", fr, v.exp_frame);
    chk("oe_hold", oe_ok, 1);
    sd_edge(1'b0);
    chk("oe_release", cmd_oe, 0);
    chk("out_idle", cmd_out, 1);
    if (v.rmode == 0) begin
      repeat (7) sd_edge(1'b0);
      chk("gap_early_irq", irq, 0);
      sd_edge(1'b0);
      chk("gap_end_irq", irq, v.irq_en);
    end else if (v.rmode == 1) begin
      repeat (4) sd_edge(1'b0);
      for (int b = 47; b >= 0; b--) begin
        cmd_in = v.resp[b];
        sd_edge(1'b0);
      end
      cmd_in = 1'b1;
    end else begin
      for (int k = 1; k < NCR; k++) sd_edge(1'b1);
      bus_read(3'd2, d);
      chk("timeout_early", d[2], 0);
      sd_edge(1'b1);
      bus_read(3'd2, d);
      chk("timeout_exact", d[2], 1);
    end
    seen = 1'b0;
    for (int k = 0; k < 800 && !seen; k++) begin
      bus_read(3'd2, d);
      seen = d[1];
    end
    chk("done_wait", seen, 1);
    chk("busy_clear", d[0], 0);
    chk("timeout", d[2], v.exp_to);
    chk("crc_err", d[3], v.exp_ce);
    chk("irq_en_rb", d[4], v.irq_en);
    chk("irq_level", irq, v.irq_en);
    if (v.rmode == 1) begin
      bus_read(3'd3, d);
      chk("resp_arg", d, v.exp_rarg);
      bus_read(3'd4, d);
      chk("resp_hdr", d, {19'b0, v.exp_hdr});
    end
    bus_write(3'd2, {27'b0, v.irq_en, 4'b0010});
    bus_read(3'd2, d);
    chk("done_cleared", d[3:1], 0);
    chk("irq_cleared", irq, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [6:0]  rc;
    time t0;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; cmd_in = 1'b1;

    vt[0] = mkv(6'd0, 32'h0, 0, 0, 0, '0, 8'd0, 0, 1);
    vt[0].exp_frame = 48'h400000000095;
    vt[1] = mkv(6'd8, 32'h1AA, 1, 1, 1, 48'h08000001AA13, 8'd0, 0, 0);
    vt[1].exp_frame = 48'h48000001AA87;
    vt[1].exp_ce = 1'b0; vt[1].exp_rarg = 32'h1AA; vt[1].exp_hdr = {7'h09, 6'd8};
    vt[2] = mkv(6'd8, 32'h1AA, 1, 1, 1, 48'h08000001AA15, 8'd0, 0, 1);
    vt[2].exp_ce = 1'b1; vt[2].exp_hdr = {7'h0A, 6'd8};
    vt[3] = mkv(6'd8, 32'h1AA, 1, 0, 1, 48'h08000001AA15, 8'd0, 0, 1);
    vt[3].exp_ce = 1'b0;
    vt[4] = mkv(6'd55, 32'hDEADBEEF, 1, 1, 2, '0, 8'd3, 0, 1);
    vt[5] = mkv(6'd17, 32'hA5A5_0F0F, 0, 0, 0, '0, 8'd3, 1, 1);
    for (int i = 6; i < 12; i++) begin
      int rm;
      bit corrupt;
      rm   = int'($urandom_range(0, 1));
      ridx = 6'($urandom);
      rarg = $urandom;
      rc   = crc_ref({2'b00, ridx, rarg});
      corrupt = 1'($urandom_range(0, 1));
      if (corrupt) rc = rc ^ 7'(1 << $urandom_range(0, 6));
      vt[i] = mkv(6'($urandom), $urandom, rm == 1, 1'($urandom_range(0, 1)), rm,
                  {2'b00, ridx, rarg, rc, 1'b1}, 8'($urandom_range(0, 2)), 0,
                  1'($urandom_range(0, 1)));
    end

    #25;
    chk("rst_readdata", readdata, 0);
    chk("rst_sd_clk", sd_clk, 0);
    chk("rst_cmd_out", cmd_out, 1);
    chk("rst_cmd_oe", cmd_oe, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd2, d); chk("rst_status", d, 0);
    bus_read(3'd5, d); chk("rst_clkdiv", d, 124);
    bus_read(3'd0, d); chk("rst_arg", d, 0);
    bus_read(3'd3, d); chk("rst_resp_arg", d, 0);
    bus_read(3'd4, d); chk("rst_resp_hdr", d, 0);
    bus_read(3'd6, d); chk("unmapped6", d, 0);
    bus_read(3'd7, d); chk("unmapped7", d, 0);
    cur_div = 8'd124;
    sd_edge(1'b1); t0 = $time; sd_edge(1'b1);
    chk("period_div124", $time - t0, 2500);

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i]);
      if (i == 0) begin
        sd_edge(1'b1); t0 = $time; sd_edge(1'b1);
        chk("period_div0", $time - t0, 20);
      end
      if (i == 5) begin
        bus_read(3'd5, d); chk("clkdiv_rb", d, 3);
        sd_edge(1'b1); t0 = $time; sd_edge(1'b1);
        chk("period_div3", $time - t0, 80);
      end
    end

    // reset in the middle of a frame
    bus_write(3'd0, 32'h12345678);
    bus_write(3'd1, 32'd17);
    for (int k = 0; k < 3000 && !cmd_oe; k++) begin
      @(posedge clk); #1;
    end
    repeat (20) sd_edge(1'b1);
    chk("midsend_oe", cmd_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cmd_oe", cmd_oe, 0);
    chk("arst_cmd_out", cmd_out, 1);
    chk("arst_sd_clk", sd_clk, 0);
    chk("arst_readdata", readdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd2, d); chk("arst_status", d, 0);
    bus_read(3'd5, d); chk("arst_clkdiv", d, 124);
    bus_read(3'd0, d); chk("arst_arg", d, 0);
    cur_div = 8'd124;
    run_vec(mkv(6'd17, 32'h12345678, 0, 0, 0, '0, 8'd0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
